// File: rtl/sha_loader_pkg.sv
// Shared types and constants for the SHA-256 message loader.
// The padding engine is compiled in only when SHA_LOADER_PAD_EN is defined.
package sha_loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD80,
    ST_PADZ,
    ST_LEN,
    ST_HOLD
  } state_e;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_LANE    = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  // Lane indices derived from the block geometry
  localparam logic [5:0] LAST_LANE    = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0] PRE_LEN_LANE = 6'(LEN_LANE - 1);

endpackage

// File: rtl/sha_len_counter.sv
// Message bit-length counter for the SHA-256 loader: LEN_W bits, +8 per byte,
// built from cascaded 8-bit stages, with a byte-select read of the 64-bit
// big-endian length field (lane_i 0 -> length lane 56, most significant byte).
// Only needed by the padding engine, so it exists only when SHA_LOADER_PAD_EN
// is defined.
`ifdef SHA_LOADER_PAD_EN
module sha_len_counter
  import sha_loader_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       inc_i,
  input  logic       clr_i,
  input  logic [2:0] lane_i,
  output logic [7:0] byte_o
);

  localparam int NST = (LEN_W + 7) / 8;
  // Bits at or above LEN_W are held at zero so the count wraps mod 2^LEN_W
  localparam logic [NST*8-1:0] MASK = {(NST*8){1'b1}} >> (NST*8 - LEN_W);

  logic [NST-1:0]   carry;
  logic [NST*8-1:0] flat;
  logic [7:0]       field [8];

  // Stage 0 receives the +8 request; higher stages receive ripple carries
  assign carry[0] = inc_i;

  for (genvar gi = 0; gi < NST; gi++) begin : g_stage
    logic [7:0] stage_q;
    logic [7:0] addend;

    if (gi == 0) begin : g_lsb
      assign addend = {4'd0, carry[0], 3'd0};
      if (NST > 1) begin : g_co
        assign carry[1] = carry[0] & (stage_q[7:3] == 5'h1f);
      end
    end else begin : g_upper
      assign addend = {7'd0, carry[gi]};
      if (gi < NST - 1) begin : g_co
        assign carry[gi+1] = carry[gi] & (stage_q == 8'hff);
      end
    end

    // One 8-bit slice of the counter; clears at reset and at end of message
    always_ff @(posedge clk) begin
      if (srst || clr_i) begin
        stage_q <= 8'h00;
      end else begin
        stage_q <= (stage_q + addend) & MASK[gi*8 +: 8];
      end
    end

    assign flat[gi*8 +: 8] = stage_q;
  end

  // Map counter bytes onto the 64-bit length field; missing bytes read zero
  for (genvar gi = 0; gi < 8; gi++) begin : g_field
    if (gi < NST) begin : g_have
      assign field[gi] = flat[gi*8 +: 8];
    end else begin : g_zero
      assign field[gi] = 8'h00;
    end
  end

  assign byte_o = field[3'd7 - lane_i];

endmodule
`endif

// File: rtl/sha_msg_loader.sv
// Byte-serial SHA-256 message loader feeding the 64-byte block register bank.
// Define SHA_LOADER_PAD_EN to compile in the padding engine (0x80, zero fill,
// 64-bit big-endian length); without it upstream supplies pre-padded blocks
// and IN_LAST only flags the block containing it as final.
module sha_msg_loader
  import sha_loader_pkg::*;
`ifdef SHA_LOADER_PAD_EN
#(
  parameter int LEN_W = 64
)
`endif
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  input  logic       IN_LAST,
  output logic       IN_READY,
  output logic [7:0] WR_D,
  output logic [5:0] WR_ADDR,
  output logic       WR_EN_N,
  output logic       BLK_VALID,
  output logic       BLK_FINAL,
  input  logic       BLK_ACK
);

  state_e     state_q;
  logic [5:0] ptr_q;
  logic [5:0] ptr_d;
  logic       final_q;
  logic       in_ready_q;
  logic       wr_en_n_q;
  logic [7:0] wr_d_q;
  logic [5:0] wr_addr_q;
  logic       blk_valid_q;
  logic       blk_final_q;
  logic       accept;
  logic       ack;

  assign ptr_d  = ptr_q + 6'd1;
  assign accept = (state_q == ST_FILL) && IN_VALID && in_ready_q;
  // An ack only counts once the block has actually been presented
  assign ack    = (state_q == ST_HOLD) && BLK_ACK && blk_valid_q;

`ifdef SHA_LOADER_PAD_EN
  state_e     pend_q;
  logic       len_clr;
  logic [7:0] len_byte;

  assign len_clr = ack && final_q;

  sha_len_counter #(
    .LEN_W (LEN_W)
  ) u_len (
    .clk    (CLK),
    .srst   (RST),
    .inc_i  (accept),
    .clr_i  (len_clr),
    .lane_i (ptr_q[2:0]),
    .byte_o (len_byte)
  );
`endif

  // Sequencer: byte handshake, bank writes, padding and block hand-off
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_FILL;
      ptr_q       <= 6'd0;
      final_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      wr_en_n_q   <= 1'b1;
      wr_d_q      <= 8'h00;
      wr_addr_q   <= 6'd0;
      blk_valid_q <= 1'b0;
      blk_final_q <= 1'b0;
`ifdef SHA_LOADER_PAD_EN
      pend_q      <= ST_FILL;
`endif
    end else begin
      wr_en_n_q  <= 1'b1;
      in_ready_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            wr_en_n_q <= 1'b0;
            wr_d_q    <= IN_DATA;
            wr_addr_q <= ptr_q;
            ptr_q     <= ptr_d;
`ifdef SHA_LOADER_PAD_EN
            if (IN_LAST || ptr_q == LAST_LANE) begin
              in_ready_q <= 1'b0;
            end
            if (ptr_q == LAST_LANE) begin
              // A last byte in lane 63 defers the 0x80 to lane 0 of the next block
              state_q <= ST_HOLD;
              pend_q  <= IN_LAST ? ST_PAD80 : ST_FILL;
            end else if (IN_LAST) begin
              state_q <= ST_PAD80;
            end
`else
            final_q <= final_q | IN_LAST;
            if (ptr_q == LAST_LANE) begin
              in_ready_q <= 1'b0;
              state_q    <= ST_HOLD;
            end
`endif
          end
        end
`ifdef SHA_LOADER_PAD_EN
        ST_PAD80, ST_PADZ: begin
          wr_en_n_q <= 1'b0;
          wr_addr_q <= ptr_q;
          wr_d_q    <= (state_q == ST_PAD80) ? PAD_BYTE : 8'h00;
          ptr_q     <= ptr_d;
          if (ptr_q == PRE_LEN_LANE) begin
            state_q <= ST_LEN;
          end else if (ptr_q == LAST_LANE) begin
            // No room for the length here: finish this block, continue zero fill after ack
            state_q <= ST_HOLD;
            pend_q  <= ST_PADZ;
          end else begin
            state_q <= ST_PADZ;
          end
        end
        ST_LEN: begin
          wr_en_n_q <= 1'b0;
          wr_addr_q <= ptr_q;
          wr_d_q    <= len_byte;
          ptr_q     <= ptr_d;
          if (ptr_q == LAST_LANE) begin
            state_q <= ST_HOLD;
            final_q <= 1'b1;
            pend_q  <= ST_FILL;
          end
        end
`endif
        ST_HOLD: begin
          blk_valid_q <= 1'b1;
          blk_final_q <= final_q;
          if (ack) begin
            blk_valid_q <= 1'b0;
            blk_final_q <= 1'b0;
            final_q     <= 1'b0;
            ptr_q       <= 6'd0;
            state_q     <= ST_FILL;
            in_ready_q  <= 1'b1;
`ifdef SHA_LOADER_PAD_EN
            // A pending pad resumes immediately with its lane-0 write
            if (pend_q != ST_FILL) begin
              in_ready_q <= 1'b0;
              wr_en_n_q  <= 1'b0;
              wr_addr_q  <= 6'd0;
              wr_d_q     <= (pend_q == ST_PAD80) ? PAD_BYTE : 8'h00;
              ptr_q      <= 6'd1;
              state_q    <= ST_PADZ;
            end
            pend_q <= ST_FILL;
`endif
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign WR_D      = wr_d_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_EN_N   = wr_en_n_q;
  assign BLK_VALID = blk_valid_q;
  assign BLK_FINAL = blk_final_q;

endmodule

// File: tb/tb_sha_msg_loader.sv
// Scoreboard bench for sha_msg_loader: random messages with random valid
// gaps and ack delays; expected bank writes and blocks come from a
// whole-message padding model (or raw blocks when SHA_LOADER_PAD_EN is off).
module tb_sha_msg_loader;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_LAST;
  logic       IN_READY;
  logic [7:0] WR_D;
  logic [5:0] WR_ADDR;
  logic       WR_EN_N;
  logic       BLK_VALID;
  logic       BLK_FINAL;
  logic       BLK_ACK;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          blk_seen = 0;
  int          ack_cnt  = 0;
  bit          mon_en   = 1'b0;
  logic [13:0] exp_wr[$];
  bit          exp_blk[$];
  logic [7:0]  msg_q[$];
  int          last_pos;

  always #5 CLK = ~CLK;

  sha_msg_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_DATA   (IN_DATA),
    .IN_LAST   (IN_LAST),
    .IN_READY  (IN_READY),
    .WR_D      (WR_D),
    .WR_ADDR   (WR_ADDR),
    .WR_EN_N   (WR_EN_N),
    .BLK_VALID (BLK_VALID),
    .BLK_FINAL (BLK_FINAL),
    .BLK_ACK   (BLK_ACK)
  );

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference model: expected writes and block flags for the whole message
  task automatic build_expect();
`ifdef SHA_LOADER_PAD_EN
    logic [7:0]  p[$];
    logic [63:0] bits;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[k*8 +: 8]);
    for (int i = 0; i < p.size(); i++) exp_wr.push_back({6'(i % 64), p[i]});
    for (int b = 0; b < p.size() / 64; b++) exp_blk.push_back(b == p.size() / 64 - 1);
`else
    for (int i = 0; i < msg_q.size(); i++) exp_wr.push_back({6'(i % 64), msg_q[i]});
    for (int b = 0; b < msg_q.size() / 64; b++) exp_blk.push_back(b == last_pos / 64);
`endif
  endtask

  task automatic make_msg(input int len, input int lpos);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    last_pos = lpos;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      IN_VALID = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = last;
    while (!acc) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      n++;
      if (n > 2000) begin
        check("accept_timeout", acc, 64'(n), 64'd2000);
        break;
      end
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_DATA  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_msg();
    build_expect();
    $display("message len=%0d last_pos=%0d", msg_q.size(), last_pos);
    for (int i = 0; i < msg_q.size(); i++) send_byte(msg_q[i], i == last_pos);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_wr.size() != 0 || exp_blk.size() != 0) begin
      @(posedge CLK);
      #1;
      n++;
      if (n > 3000) begin
        check("drain_timeout", 1'b0 == 1'b1 && n == 0, 64'(exp_wr.size()), 64'd0);
        exp_wr.delete();
        exp_blk.delete();
        break;
      end
    end
    repeat (20) @(posedge CLK);
    #1;
  endtask

  // Reset takes effect on the next edge; check all outputs just after it
  task automatic check_reset_vals();
    @(posedge CLK);
    @(negedge CLK);
    check("rst_wr_en_n",   WR_EN_N == 1'b1,   64'(WR_EN_N),   64'd1);
    check("rst_wr_d",      WR_D == 8'h00,     64'(WR_D),      64'd0);
    check("rst_wr_addr",   WR_ADDR == 6'd0,   64'(WR_ADDR),   64'd0);
    check("rst_blk_valid", BLK_VALID == 1'b0, 64'(BLK_VALID), 64'd0);
    check("rst_blk_final", BLK_FINAL == 1'b0, 64'(BLK_FINAL), 64'd0);
    check("rst_in_ready",  IN_READY == 1'b0,  64'(IN_READY),  64'd0);
  endtask

  task automatic reset_abort();
    mon_en = 1'b0;
    RST = 1'b1;
    check_reset_vals();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_wr.delete();
    exp_blk.delete();
    mon_en = 1'b1;
  endtask

  // Compression-stage model: ack each block after a random or long delay
  initial begin
    int d;
    BLK_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (BLK_VALID && mon_en && !RST) begin
        d = (ack_cnt % 3 == 0) ? 10 : $urandom_range(0, 3);
        repeat (d) @(negedge CLK);
        @(posedge CLK);
        #1 BLK_ACK = 1'b1;
        @(posedge CLK);
        #1 BLK_ACK = 1'b0;
        ack_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on every bank write and block presentation
  initial begin
    logic [13:0] e;
    bit          exp_final;
    bit          prev_valid;
    bit          prev_ack;
    bit          prev_wr63;
    bit          quiet_ok;
    prev_valid = 1'b0;
    prev_ack   = 1'b0;
    prev_wr63  = 1'b0;
    quiet_ok   = 1'b1;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        prev_valid = 1'b0;
        prev_ack   = 1'b0;
        prev_wr63  = 1'b0;
        continue;
      end
      if (prev_ack) begin
        check("valid_drop_after_ack", BLK_VALID == 1'b0, 64'(BLK_VALID), 64'd0);
        check("resume_after_ack", IN_READY || !WR_EN_N, {62'd0, IN_READY, !WR_EN_N}, 64'd1);
        check("hold_quiet", quiet_ok, 64'(quiet_ok), 64'd1);
      end
      if (!WR_EN_N) begin
        check("write_expected", exp_wr.size() != 0, {50'd0, WR_ADDR, WR_D}, 64'd0);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("bank_write", {WR_ADDR, WR_D} == e, {50'd0, WR_ADDR, WR_D}, {50'd0, e});
        end
      end
      if (BLK_VALID && !prev_valid) begin
        blk_seen++;
        $display("block %0d presented final=%0b", blk_seen, BLK_FINAL);
        check("blk_after_lane63", prev_wr63, 64'(prev_wr63), 64'd1);
        check("block_expected", exp_blk.size() != 0, 64'(blk_seen), 64'd0);
        if (exp_blk.size() != 0) begin
          exp_final = exp_blk.pop_front();
          check("blk_final", BLK_FINAL == exp_final, 64'(BLK_FINAL), 64'(exp_final));
        end
        quiet_ok = 1'b1;
      end
      if (BLK_VALID && (IN_READY || !WR_EN_N)) quiet_ok = 1'b0;
      prev_ack   = BLK_VALID && BLK_ACK;
      prev_valid = BLK_VALID;
      prev_wr63  = !WR_EN_N && WR_ADDR == 6'd63;
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", chk_cnt);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA  = 8'h00;
    IN_LAST  = 1'b0;
    check_reset_vals();
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    mon_en = 1'b1;
`ifdef SHA_LOADER_PAD_EN
    msg_q = {8'h61, 8'h62, 8'h63};
    last_pos = 2;
    send_msg();
    foreach (msg_q[i]) ;
    for (int t = 0; t < 4; t++) begin
      int lens [4];
      lens = '{55, 56, 63, 64};
      make_msg(lens[t], lens[t] - 1);
      send_msg();
    end
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(1, 130);
      make_msg(len, len - 1);
      send_msg();
    end
    wait_drain();
    // Abort in the middle of the zero fill
    msg_q = {8'h61, 8'h62, 8'h63};
    last_pos = 2;
    send_msg();
    repeat (8) @(posedge CLK);
    #1;
    reset_abort();
    msg_q = {8'h61, 8'h62, 8'h63};
    last_pos = 2;
    send_msg();
`else
    make_msg(64, 63);
    send_msg();
    make_msg(128, 127);
    send_msg();
    for (int t = 0; t < 5; t++) begin
      int k;
      k = $urandom_range(1, 3);
      make_msg(64 * k, 64 * (k - 1) + $urandom_range(0, 63));
      send_msg();
    end
    wait_drain();
    // Abort part-way through a block
    make_msg(20, -1);
    send_msg();
    repeat (3) @(posedge CLK);
    #1;
    reset_abort();
    make_msg(64, 63);
    send_msg();
`endif
    wait_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
